csa_add_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `csa_38bit` carry-select adder among up to 8 requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, drives the shared adder, and registers the sum, carry-out and requester ID into a single-entry response buffer with its own valid/ready handshake. It sits between operand producers (accumulators, address generators) and the single adder instance the design budgets for.

---
 rtl/csa_add_arbiter.sv | 146 ++++++++++++++
 tb/tb_csa_add_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_add_arbiter.sv
// Round-robin arbiter that time-shares one 38-bit carry-select adder among NREQ
// requesters and registers each result into a single-entry response buffer.

module csa_38bit (
    input  logic [37:0] a,
    input  logic [37:0] b,
    input  logic        cin,
    output logic [37:0] sum,
    output logic        cout
);
    localparam int WIDTH = 38;
    localparam int BLK   = 8;
    localparam int NBLK  = (WIDTH + BLK - 1) / BLK;

    logic [NBLK:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[NBLK];

    // Each block precomputes both carry-in outcomes; the incoming carry only picks one.
    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        localparam int LO = i * BLK;
        localparam int W  = (WIDTH - LO < BLK) ? (WIDTH - LO) : BLK;

        logic [W:0] s0;
        logic [W:0] s1;

        assign s0 = {1'b0, a[LO +: W]} + {1'b0, b[LO +: W]};
        assign s1 = {1'b0, a[LO +: W]} + {1'b0, b[LO +: W]} + {{W{1'b0}}, 1'b1};

        assign sum[LO +: W]  = carry[i] ? s1[W-1:0] : s0[W-1:0];
        assign carry[i + 1]  = carry[i] ? s1[W]     : s0[W];
    end
endmodule

module csa_add_arbiter #(
    parameter int WIDTH = 38,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ*WIDTH-1:0] i_add_term1,
    input  logic [NREQ*WIDTH-1:0] i_add_term2,
    output logic [NREQ-1:0]       o_req_ready,
    output logic                  o_rsp_valid,
    output logic [WIDTH-1:0]      o_rsp_sum,
    output logic                  o_rsp_cout,
    output logic [IDW-1:0]        o_rsp_id,
    input  logic                  i_rsp_ready
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    localparam logic [IDW:0]   NREQ_W = (IDW + 1)'(NREQ);
    localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);

    buf_state_e       state;
    buf_state_e       state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   rr_ptr_nxt;
    logic [IDW-1:0]   win_id;
    logic             any_win;
    logic             can_accept;
    logic             grant;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    assign o_rsp_valid = (state == FULL);
    assign can_accept  = !o_rsp_valid || i_rsp_ready;

    // Scan valids starting at rr_ptr; the first set bit in rotated order wins.
    always_comb begin
        logic [2*NREQ-1:0] rot;
        logic [IDW:0]      cand;
        // NOTE: every variable written here gets a default before any branch, so no latch is inferred.
        win_id  = '0;
        any_win = 1'b0;
        cand    = '0;
        rot     = {i_req_valid, i_req_valid} >> rr_ptr;
        for (int off = 0; off < NREQ; off++) begin
            if (!any_win && rot[off]) begin
                any_win = 1'b1;
                cand    = {1'b0, rr_ptr} + (IDW + 1)'(off);
                if (cand >= NREQ_W) begin
                    cand = cand - NREQ_W;
                end
                win_id = cand[IDW-1:0];
            end
        end
    end

    // Reset gates the grant so no operands are consumed while rst_n is low.
    assign grant = rst_n && can_accept && any_win;

    always_comb begin
        o_req_ready         = '0;
        o_req_ready[win_id] = grant;
    end

    assign add_a = i_add_term1[win_id*WIDTH +: WIDTH];
    assign add_b = i_add_term2[win_id*WIDTH +: WIDTH];

    csa_38bit u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        if (grant) begin
            state_nxt  = FULL;
            rr_ptr_nxt = (win_id == LAST) ? '0 : win_id + 1'b1;
        end else if (o_rsp_valid && i_rsp_ready) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state      <= EMPTY;
            rr_ptr     <= '0;
            o_rsp_sum  <= '0;
            o_rsp_cout <= 1'b0;
            o_rsp_id   <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            if (grant) begin
                o_rsp_sum  <= add_sum;
                o_rsp_cout <= add_cout;
                o_rsp_id   <= win_id;
            end
        end
    end
endmodule

// File: tb/tb_csa_add_arbiter.sv
// Self-checking bench for csa_add_arbiter: directed scenarios plus a randomized
// soak scored against a cycle-level behavioural model.

module tb_csa_add_arbiter;
    localparam int W    = 38;
    localparam int NREQ = 8;
    localparam int IDW  = $clog2(NREQ);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           cout;
        logic [W-1:0]   sum;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] term1;
    logic [NREQ*W-1:0] term2;
    logic              rsp_ready;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic [IDW-1:0]    rsp_id;

    int total = 0;
    int bad   = 0;

    // Behavioural model: response buffer contents and round-robin start index.
    int           m_ptr;
    bit           m_valid;
    logic [W-1:0] m_sum;
    logic         m_cout;
    int           m_id;

    always #5 clk = ~clk;

    csa_add_arbiter #(.WIDTH(W), .NREQ(NREQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .i_add_term1 (term1),
        .i_add_term2 (term2),
        .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid),
        .o_rsp_sum   (rsp_sum),
        .o_rsp_cout  (rsp_cout),
        .o_rsp_id    (rsp_id),
        .i_rsp_ready (rsp_ready)
    );

    function automatic logic [W-1:0] rand_op();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        term1[k*W +: W] = a;
        term2[k*W +: W] = b;
    endtask

    // Winner under the current inputs, or -1 when nothing is granted.
    function automatic int model_winner();
        if (!rst_n || (m_valid && !rsp_ready)) return -1;
        for (int off = 0; off < NREQ; off++) begin
            if (req_valid[(m_ptr + off) % NREQ]) return (m_ptr + off) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int k);
        logic [NREQ-1:0] r;
        r = '0;
        if (k >= 0) r[k] = 1'b1;
        return r;
    endfunction

    task automatic model_clock();
        int k;
        logic [W:0] full;
        k = model_winner();
        if (!rst_n) begin
            m_valid = 0; m_sum = '0; m_cout = 1'b0; m_id = 0; m_ptr = 0;
        end else if (k >= 0) begin
            full    = {1'b0, term1[k*W +: W]} + {1'b0, term2[k*W +: W]};
            m_sum   = full[W-1:0];
            m_cout  = full[W];
            m_id    = k;
            m_valid = 1;
            m_ptr   = (k + 1) % NREQ;
        end else if (m_valid && rsp_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic cycle();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_valid[0] = 1'b1;
        rsp_ready = 1'b1;
        term1 = '0;
        term2 = '0;
        cycle();
        cycle();
        total++;
        if (req_ready !== '0) begin
            bad++; $display("FAIL reset_ready got=%h want=0", req_ready);
        end
        total++;
        if ({rsp_valid, rsp_cout, rsp_id, rsp_sum} !== '0) begin
            bad++; $display("FAIL reset_outputs got valid=%b cout=%b id=%0d sum=%h want all 0",
                            rsp_valid, rsp_cout, rsp_id, rsp_sum);
        end
    endtask

    task automatic test_basic();
        rst_n = 1'b1;
        req_valid = 8'h01;
        set_op(0, 38'd5, 38'd7);
        #1;
        total++;
        if (req_ready !== 8'h01) begin
            bad++; $display("FAIL basic_ready got=%h want=01", req_ready);
        end
        cycle();
        req_valid = '0;
        total++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 38'd12 || rsp_cout !== 1'b0 || rsp_id !== 3'd0) begin
            bad++; $display("FAIL basic_rsp got valid=%b sum=%0d cout=%b id=%0d want 1/12/0/0",
                            rsp_valid, rsp_sum, rsp_cout, rsp_id);
        end
        #1;
        cycle();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL basic_drain got valid=%b want=0", rsp_valid);
        end
    endtask

    task automatic test_carry();
        logic [W-1:0] ones;
        ones = '1;
        req_valid = 8'h08;
        set_op(3, 38'h20_0000_0000, 38'h20_0000_0000);
        #1;
        total++;
        if (req_ready !== 8'h08) begin
            bad++; $display("FAIL carry_single_ready got=%h want=08", req_ready);
        end
        cycle();
        total++;
        if (rsp_sum !== '0 || rsp_cout !== 1'b1 || rsp_id !== 3'd3) begin
            bad++; $display("FAIL carry_msb got sum=%h cout=%b id=%0d want 0/1/3", rsp_sum, rsp_cout, rsp_id);
        end
        req_valid = 8'h20;
        set_op(5, ones, 38'd1);
        #1;
        cycle();
        total++;
        if (rsp_sum !== '0 || rsp_cout !== 1'b1 || rsp_id !== 3'd5) begin
            bad++; $display("FAIL carry_ripple got sum=%h cout=%b id=%0d want 0/1/5", rsp_sum, rsp_cout, rsp_id);
        end
        req_valid = '0;
        #1;
        cycle();
    endtask

    task automatic test_round_robin();
        int exp_ids[6] = '{0, 1, 2, 3, 0, 1};
        pulse_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) set_op(k, rand_op(), rand_op());
        req_valid = 8'h0F;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (req_ready !== onehot(model_winner())) begin
                bad++; $display("FAIL rr_ready[%0d] got=%h want=%h", i, req_ready, onehot(model_winner()));
            end
            cycle();
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_ids[i][IDW-1:0] || rsp_sum !== m_sum || rsp_cout !== m_cout) begin
                bad++; $display("FAIL rr_rsp[%0d] got id=%0d sum=%h cout=%b want id=%0d sum=%h cout=%b",
                                i, rsp_id, rsp_sum, rsp_cout, exp_ids[i], m_sum, m_cout);
            end
            set_op(m_id, rand_op(), rand_op());
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (req_ready !== '0) begin
                bad++; $display("FAIL bp_ready[%0d] got=%h want=0", i, req_ready);
            end
            cycle();
            total++;
            if (rsp_valid !== 1'b1 || rsp_sum !== m_sum || rsp_cout !== m_cout || rsp_id !== m_id[IDW-1:0]) begin
                bad++; $display("FAIL bp_hold[%0d] got id=%0d sum=%h want id=%0d sum=%h", i, rsp_id, rsp_sum, m_id, m_sum);
            end
        end
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 8'h04) begin
            bad++; $display("FAIL bp_release_ready got=%h want=04", req_ready);
        end
        cycle();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 3'd2 || rsp_sum !== m_sum) begin
            bad++; $display("FAIL bp_no_bubble got valid=%b id=%0d sum=%h want 1/2/%h", rsp_valid, rsp_id, rsp_sum, m_sum);
        end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        rsp_ready = 1'b0;
        req_valid = 8'h04;
        set_op(2, rand_op(), rand_op());
        set_op(5, rand_op(), rand_op());
        #1;
        cycle();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 3'd2) begin
            bad++; $display("FAIL mid_fill got valid=%b id=%0d want 1/2", rsp_valid, rsp_id);
        end
        req_valid = 8'h24;
        rst_n = 1'b0;
        #1;
        total++;
        if (req_ready !== '0) begin
            bad++; $display("FAIL mid_rst_ready got=%h want=0", req_ready);
        end
        cycle();
        total++;
        if (rsp_valid !== 1'b0 || rsp_sum !== '0 || rsp_id !== '0) begin
            bad++; $display("FAIL mid_discard got valid=%b sum=%h id=%0d want 0/0/0", rsp_valid, rsp_sum, rsp_id);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 8'h04) begin
            bad++; $display("FAIL mid_ptr_cleared got=%h want=04", req_ready);
        end
        cycle();
        rsp_ready = 1'b1;
        req_valid = 8'h20;
        #1;
        cycle();
        total++;
        if (rsp_id !== 3'd5 || rsp_sum !== m_sum) begin
            bad++; $display("FAIL mid_next got id=%0d sum=%h want 5/%h", rsp_id, rsp_sum, m_sum);
        end
        req_valid = '0;
        #1;
        cycle();
    endtask

    task automatic test_random_soak();
        bit   pending[NREQ];
        int   wait_cnt[NREQ];
        rsp_t q[$];
        rsp_t exp;
        int   k;
        logic [W:0] full;
        pulse_reset();
        for (int j = 0; j < NREQ; j++) begin
            pending[j] = 0; wait_cnt[j] = 0;
        end
        for (int i = 0; i < 2500; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!pending[j] && $urandom_range(1, 0) == 1) begin
                    pending[j] = 1;
                    set_op(j, rand_op(), rand_op());
                end
                req_valid[j] = (i < 2400) ? pending[j] : 1'b0;
            end
            rsp_ready = (i >= 2400) || ($urandom_range(9, 0) < 7);
            #1;
            k = model_winner();
            total++;
            if (req_ready !== onehot(k)) begin
                bad++; $display("FAIL soak_ready[%0d] got=%h want=%h", i, req_ready, onehot(k));
            end
            if (rsp_valid === 1'b1 && rsp_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL soak_dup[%0d] got id=%0d want no response", i, rsp_id);
                end else begin
                    exp = q.pop_front();
                    if (rsp_id !== exp.id || rsp_sum !== exp.sum || rsp_cout !== exp.cout) begin
                        bad++; $display("FAIL soak_rsp[%0d] got id=%0d sum=%h cout=%b want id=%0d sum=%h cout=%b",
                                        i, rsp_id, rsp_sum, rsp_cout, exp.id, exp.sum, exp.cout);
                    end
                end
            end
            if (!m_valid || rsp_ready) begin
                for (int j = 0; j < NREQ; j++) if (req_valid[j]) wait_cnt[j]++;
            end
            if (k >= 0) begin
                total++;
                if (wait_cnt[k] > NREQ) begin
                    bad++; $display("FAIL soak_fair id=%0d got wait=%0d want<=%0d", k, wait_cnt[k], NREQ);
                end
                full = {1'b0, term1[k*W +: W]} + {1'b0, term2[k*W +: W]};
                q.push_back('{id: k[IDW-1:0], cout: full[W], sum: full[W-1:0]});
                pending[k]  = 0;
                wait_cnt[k] = 0;
            end
            cycle();
        end
        total++;
        if (q.size() != 0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL soak_lost got pending=%0d valid=%b want 0/0", q.size(), rsp_valid);
        end
    endtask

    initial begin
        m_ptr = 0; m_valid = 0; m_sum = '0; m_cout = 1'b0; m_id = 0;
        test_reset();
        test_basic();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
